// File: rtl/csk_addsub_seq.sv
// -----------------------------------------------------------------------------
// csk_addsub_seq
//   Multi-cycle add/subtract engine. Computes A+B+Cin (sub=0) or A-B-Cin
//   (sub=1, evaluated as A + ~B + ~Cin). Each clock resolves K result bits
//   through one carry-skip block, and the carry is held in a register between
//   blocks. An operation takes n/K cycles from accept to out_valid.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operand bundle valid        in_ready   engine idle, can accept
//   A, B       operands (n bits)           Cin        carry-in / borrow-in
//   sub        0 = add, 1 = subtract
//   out_valid  result valid                out_ready  consumer takes result
//   S          result (n bits)             Cout       carry-out (1 = no borrow)
//   V          two's-complement signed overflow
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module csk_addsub_seq #(
  parameter int n = 32,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  input  logic         Cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] S,
  output logic         Cout,
  output logic         V
);

  localparam int NCH = n / K;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCH - 1);

  // Reject parameter combinations that cannot be split into whole blocks.
  if ((K < 1) || (K > n) || ((n % K) != 0)) begin : g_bad_params
    $error("csk_addsub_seq: n must be a positive multiple of K and K <= n");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One carry-skip block: ripple the sum, but when every bit propagates the
  // block carry-out is taken straight from the block carry-in.
  // Returns {carry_out, sum[K-1:0]}.
  function automatic logic [K:0] csk_block(input logic [K-1:0] a,
                                           input logic [K-1:0] b,
                                           input logic         cin);
    logic [K-1:0] p;
    logic [K-1:0] sum;
    logic         c;
    p = a ^ b;
    c = cin;
    for (int i = 0; i < K; i++) begin
      sum[i] = p[i] ^ c;
      c      = (a[i] & b[i]) | (p[i] & c);
    end
    return {((&p) ? cin : c), sum};
  endfunction

  state_e          state_q,     state_d;
  logic [n-1:0]    a_q,         a_d;
  logic [n-1:0]    b_q,         b_d;       // effective B (inverted for sub)
  logic            carry_q,     carry_d;
  logic [CW-1:0]   cnt_q,       cnt_d;
  logic [n-1:0]    s_q,         s_d;
  logic            cout_q,      cout_d;
  logic            v_q,         v_d;
  logic            in_ready_q,  in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic [K:0]      blk_s;
  logic [K-1:0]    a_chunk_s;
  logic [K-1:0]    b_chunk_s;

  // Operand slice for the block currently being resolved.
  always_comb begin
    a_chunk_s = a_q[int'(cnt_q) * K +: K];
    b_chunk_s = b_q[int'(cnt_q) * K +: K];
    blk_s     = csk_block(a_chunk_s, b_chunk_s, carry_q);
  end

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    s_d         = s_q;
    cout_d      = cout_q;
    v_d         = v_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d        = A;
          b_d        = sub ? ~B : B;
          carry_d    = sub ? ~Cin : Cin;
          cnt_d      = '0;
          state_d    = ST_RUN;
          in_ready_d = 1'b0;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        s_d[int'(cnt_q) * K +: K] = blk_s[K-1:0];
        carry_d                   = blk_s[K];
        if (cnt_q == LAST_CHUNK) begin
          cout_d      = blk_s[K];
          // blk_s[K-1] is the new result MSB on the last block.
          v_d         = (a_q[n-1] == b_q[n-1]) && (blk_s[K-1] != a_q[n-1]);
          cnt_d       = '0;
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        cnt_d       = '0;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      v_q         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      s_q         <= s_d;
      cout_q      <= cout_d;
      v_q         <= v_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign S         = s_q;
  assign Cout      = cout_q;
  assign V         = v_q;

endmodule

// File: tb/tb_csk_addsub_seq.sv
// -----------------------------------------------------------------------------
// tb_csk_addsub_seq
//   Directed self-checking bench for csk_addsub_seq (n=32, K=4), plus a short
//   random sweep against an arithmetic reference.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_csk_addsub_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        Cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] S;
  logic        Cout;
  logic        V;

  int n_checks;
  int n_fail;

  csk_addsub_seq #(.n(32), .K(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Cout      (Cout),
    .V         (V)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operand bundle, wait (bounded) for out_valid; lat = edges.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic sb, output int lat);
    @(negedge clk);
    A = a; B = b; Cin = cin; sub = sb; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Take the result: out_ready for one edge.
  task automatic release_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || S !== 32'h0 ||
        Cout !== 1'b0 || V !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b vld=%b S=%h C=%b V=%b, want 1 0 00000000 0 0",
               in_ready, out_valid, S, Cout, V);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sub();
    int lat;
    do_op(32'd3, 32'd2, 1'b0, 1'b1, lat);
    n_checks++;
    if (lat !== 8 || S !== 32'h00000001 || Cout !== 1'b1 || V !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_basic: got lat=%0d S=%h C=%b V=%b, want 8 00000001 1 0", lat, S, Cout, V);
    end
    release_op();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL done_to_idle: got vld=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
    do_op(32'd2, 32'd3, 1'b0, 1'b1, lat);
    n_checks++;
    if (lat !== 8 || S !== 32'hFFFFFFFF || Cout !== 1'b0 || V !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_borrow: got lat=%0d S=%h C=%b V=%b, want 8 ffffffff 0 0", lat, S, Cout, V);
    end
    release_op();
    do_op(32'd2, 32'd3, 1'b1, 1'b1, lat);
    n_checks++;
    if (lat !== 8 || S !== 32'hFFFFFFFE || Cout !== 1'b0 || V !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_borrow_cin: got lat=%0d S=%h C=%b V=%b, want 8 fffffffe 0 0", lat, S, Cout, V);
    end
    release_op();
  endtask

  task automatic test_add_ovf();
    int lat;
    do_op(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, lat);
    n_checks++;
    if (lat !== 8 || S !== 32'h0 || Cout !== 1'b1 || V !== 1'b0) begin
      n_fail++;
      $display("FAIL add_carry: got lat=%0d S=%h C=%b V=%b, want 8 00000000 1 0", lat, S, Cout, V);
    end
    release_op();
    do_op(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, lat);
    n_checks++;
    if (lat !== 8 || S !== 32'h80000000 || Cout !== 1'b0 || V !== 1'b1) begin
      n_fail++;
      $display("FAIL add_ovf: got lat=%0d S=%h C=%b V=%b, want 8 80000000 0 1", lat, S, Cout, V);
    end
    release_op();
    do_op(32'h80000000, 32'h1, 1'b0, 1'b1, lat);
    n_checks++;
    if (lat !== 8 || S !== 32'h7FFFFFFF || Cout !== 1'b1 || V !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_ovf: got lat=%0d S=%h C=%b V=%b, want 8 7fffffff 1 1", lat, S, Cout, V);
    end
    release_op();
    // Cin=1 in add mode, carry rippling across every block boundary.
    do_op(32'h0FFFFFFF, 32'h00000000, 1'b1, 1'b0, lat);
    n_checks++;
    if (lat !== 8 || S !== 32'h10000000 || Cout !== 1'b0 || V !== 1'b0) begin
      n_fail++;
      $display("FAIL add_cin_ripple: got lat=%0d S=%h C=%b V=%b, want 8 10000000 0 0", lat, S, Cout, V);
    end
    release_op();
  endtask

  task automatic test_backpressure();
    int lat;
    do_op(32'h10, 32'h20, 1'b0, 1'b0, lat);
    n_checks++;
    if (lat !== 8 || S !== 32'h30 || Cout !== 1'b0 || V !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_result: got lat=%0d S=%h C=%b V=%b, want 8 00000030 0 0", lat, S, Cout, V);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      A = 32'hDEAD0000 + 32'(i); B = 32'h0BAD0BAD; Cin = 1'b1; sub = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (S !== 32'h30 || Cout !== 1'b0 || V !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got S=%h C=%b V=%b vld=%b rdy=%b, want 00000030 0 0 1 0",
                 i, S, Cout, V, out_valid, in_ready);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_op();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || S !== 32'h30) begin
      n_fail++;
      $display("FAIL bp_release: got vld=%b rdy=%b S=%h, want 0 1 00000030", out_valid, in_ready, S);
    end
    // Result is held in IDLE until the next accept.
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (S !== 32'h30 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: got S=%h vld=%b, want 00000030 0", S, out_valid);
    end
    do_op(32'd100, 32'd58, 1'b0, 1'b1, lat);
    n_checks++;
    if (lat !== 8 || S !== 32'h2A || Cout !== 1'b1 || V !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_next: got lat=%0d S=%h C=%b V=%b, want 8 0000002a 1 0", lat, S, Cout, V);
    end
    release_op();
  endtask

  task automatic test_reset_midop();
    int lat;
    logic seen_valid;
    @(negedge clk);
    A = 32'h12345678; B = 32'h11111111; Cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    // Chunks 0..2 written; lower S bits now hold 0x789 from this add.
    #2;
    n_checks++;
    if (S[11:0] !== 12'h789 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_partial: got S=%h vld=%b, want S[11:0]=789 0", S, out_valid);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (S !== 32'h0 || Cout !== 1'b0 || V !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_reset: got S=%h C=%b V=%b vld=%b rdy=%b, want 00000000 0 0 0 1",
               S, Cout, V, out_valid, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid) seen_valid = 1'b1;
    end
    n_checks++;
    if (seen_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_no_pulse: got out_valid pulse=%b, want 0", seen_valid);
    end
    do_op(32'd5, 32'd7, 1'b0, 1'b1, lat);
    n_checks++;
    if (lat !== 8 || S !== 32'hFFFFFFFE || Cout !== 1'b0 || V !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset: got lat=%0d S=%h C=%b V=%b, want 8 fffffffe 0 0", lat, S, Cout, V);
    end
    release_op();
  endtask

  task automatic test_random();
    int          lat;
    logic [31:0] a, b, beff, es;
    logic [32:0] wide;
    logic        ci, sb, ec, ev;
    for (int t = 0; t < 300; t++) begin
      a  = $urandom;
      b  = $urandom;
      ci = 1'($urandom_range(1));
      sb = 1'($urandom_range(1));
      beff = sb ? ~b : b;
      wide = {1'b0, a} + {1'b0, beff} + {32'h0, (sb ? ~ci : ci)};
      es = wide[31:0];
      ec = wide[32];
      ev = (a[31] == beff[31]) && (es[31] != a[31]);
      do_op(a, b, ci, sb, lat);
      repeat ($urandom_range(3)) @(posedge clk);
      #1;
      n_checks++;
      if (lat !== 8 || out_valid !== 1'b1 || S !== es || Cout !== ec || V !== ev) begin
        n_fail++;
        $display("FAIL random[%0d]: a=%h b=%h cin=%b sub=%b got lat=%0d vld=%b S=%h C=%b V=%b, want 8 1 %h %b %b",
                 t, a, b, ci, sb, lat, out_valid, S, Cout, V, es, ec, ev);
      end
      release_op();
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = 32'h0;
    B         = 32'h0;
    Cin       = 1'b0;
    sub       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_sub();
    test_add_ovf();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
